// File: rtl/addsub_iter.sv
// Multi-cycle WIDTH-bit two's-complement add/subtract, CHUNK bits per clock, start/busy/done handshake.
// Define ADDSUB_ITER_FLAGS_EN to build the registered zero/negative flags; otherwise they are tied to 0.
module addsub_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             negative_o
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opA_q, opA_d;
    logic [WIDTH-1:0]  opB_q, opB_d;
    logic              cin_q, cin_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              overflow_q, overflow_d;

    logic [31:0]       chunkBase;
    logic [CHUNK-1:0]  chunkA;
    logic [CHUNK-1:0]  chunkB;
    logic [CHUNK:0]    chunkSum;
    logic              msbCarryIn;
    logic              lastChunk;
    logic [WIDTH-1:0]  accNext;

    assign chunkBase  = 32'(idx_q) * 32'(CHUNK);
    assign chunkA     = opA_q[chunkBase +: CHUNK];
    assign chunkB     = opB_q[chunkBase +: CHUNK];
    assign chunkSum   = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, cin_q};
    // Carry into the top bit of the slice: recovered from the sum bit since sum = a ^ b ^ cin.
    assign msbCarryIn = chunkA[CHUNK-1] ^ chunkB[CHUNK-1] ^ chunkSum[CHUNK-1];
    assign lastChunk  = (idx_q == IDXW'(N - 1));

`ifdef ADDSUB_ITER_FLAGS_EN
    logic zero_q, zero_d;
    logic negative_q, negative_d;
`endif

    always_comb begin
        accNext = acc_q;
        accNext[chunkBase +: CHUNK] = chunkSum[CHUNK-1:0];
    end

    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        cin_d      = cin_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
`ifdef ADDSUB_ITER_FLAGS_EN
        zero_d     = zero_q;
        negative_d = negative_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    opA_d   = a_i;
                    opB_d   = op_i ? ~b_i : b_i;
                    cin_d   = op_i;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = accNext;
                cin_d = chunkSum[CHUNK];
                idx_d = idx_q + IDXW'(1);
                if (lastChunk) begin
                    state_d    = DONE;
                    result_d   = accNext;
                    carry_d    = chunkSum[CHUNK];
                    overflow_d = msbCarryIn ^ chunkSum[CHUNK];
`ifdef ADDSUB_ITER_FLAGS_EN
                    zero_d     = (accNext == '0);
                    negative_d = accNext[WIDTH-1];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            cin_q      <= 1'b0;
            idx_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ADDSUB_ITER_FLAGS_EN
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            cin_q      <= cin_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
`ifdef ADDSUB_ITER_FLAGS_EN
            zero_q     <= zero_d;
            negative_q <= negative_d;
`endif
        end
    end

    assign busy_o     = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign result_o   = result_q;
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;

`ifdef ADDSUB_ITER_FLAGS_EN
    assign zero_o     = zero_q;
    assign negative_o = negative_q;
`else
    assign zero_o     = 1'b0;
    assign negative_o = 1'b0;
`endif

endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle two's-complement add/subtract unit for the sequential and pipelined datapaths. It generalises the fixed 64-bit ripple subtractor to any WIDTH, adds an add/sub mode and status flags, and processes CHUNK bits per clock. This trades latency for a short carry chain. A start/busy/done handshake connects it to the execute-stage controller, and results stay stable until the next operation is accepted.

## Interface
- WIDTH, 64: operand/result width in bits; ≥ 2.
- CHUNK, 8: bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK is the number of iterations.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising clk; accepted only when busy=0.
- op  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress; start ignored.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  output  1  carry out of bit WIDTH−1. For subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry-in(MSB) XOR carry-out(MSB).
- zero  output  1  result == 0 (see Configuration).
- negative  output  1  result[WIDTH−1] (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: the unit latches a, op, and op ? ~b : b into internal registers. It sets carry register = op (1 for subtract) and chunk index = 0, then moves to RUN.
- DONE with start=0 → IDLE.
- RUN: each cycle adds CHUNK bits [i·CHUNK +: CHUNK] of the latched operands plus the carry register. It writes that result slice and updates the carry register. Index i increments; when i == N−1, the state moves to DONE.
- In the final chunk, the unit also captures the carry into bit WIDTH−1 to form overflow.
- a, b and op are don't-care after acceptance; changes while busy have no effect.
- start while busy=1 is dropped, not queued.
- result, carry, overflow, zero and negative update only on the transition into DONE. They hold until the next transition into DONE or until reset; intermediate slices go to an internal register.
- Reset at any time forces IDLE and clears all outputs: busy=0, done=0, result=0, carry=0, overflow=0, zero=0, negative=0. An operation in flight is discarded.
- Arithmetic is identical to a WIDTH-bit ripple adder with cin=op and b inverted when op=1. It has no dependence on CHUNK.

## Timing
- Acceptance edge E0 (start=1, busy=0): busy=1 after E0.
- Chunks are computed on edges E1…EN. After EN: busy=0, done=1, outputs valid.
- Latency is N cycles from acceptance to done.
- done is high for exactly one cycle, in state DONE.
- A start held high during DONE is accepted on edge EN+1. This gives back-to-back throughput of one operation per N+1 cycles; busy rises after EN+1 and done falls.
- A start held continuously high re-issues an operation every N+1 cycles.
- CHUNK == WIDTH (N=1): done follows acceptance by one cycle.
- reset has priority over start on the same edge.

## Configuration
- ADDSUB_ITER_FLAGS_EN defined: zero and negative are registered with the other outputs in DONE, as above.
- ADDSUB_ITER_FLAGS_EN undefined: zero and negative are tied to 0, and no flag logic is built. Ports remain so instantiations are unchanged.
- carry and overflow are always built, in both configurations.

## Test plan
- WIDTH=64, CHUNK=8, with flags. op=0, a=0x7FFF_FFFF_FFFF_FFFF, b=1 → done 8 cycles after acceptance. result=0x8000_0000_0000_0000, carry=0, overflow=1, zero=0, negative=1.
- op=1, a=b=5 → result=0, carry=1, overflow=0, zero=1, negative=0.
- op=1, a=0, b=1 → result=0xFFFF_FFFF_FFFF_FFFF, carry=0, overflow=0, negative=1.
- op=1, a=0x8000_0000_0000_0000, b=1 → result=0x7FFF_FFFF_FFFF_FFFF, carry=1, overflow=1, negative=0.
- Handshake:
  - A start pulse at cycle 3 of a RUN is ignored, and the first result is unchanged.
  - With start held high through DONE, the second operation is accepted at EN+1, and done for it appears 9 cycles after the first done.
  - Operands changed mid-RUN do not alter the result.
- Reset and config corners:
  - reset asserted after 4 chunks → next cycle busy=0, done=0, all outputs 0; no done pulse follows.
  - With WIDTH=32, CHUNK=32: 0xFFFF_FFFF+1 gives result=0, carry=1, done one cycle after acceptance.
  - With ADDSUB_ITER_FLAGS_EN undefined, the 5−5 case gives zero=0.
